// File: rtl/pkg_64b_split_pkg.sv
// Shared types and bus widths for the 64-bit packet splitter.
package pkg_64b_split_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_P1, ST_P2, ST_DROP} route_t;
  localparam int BUS_W  = 64;
  localparam int KEEP_W = 8;
endpackage

// File: rtl/taxi_axis_if.sv
// AXI-Stream bundle with optional sideband fields gated by *_EN flags.
interface taxi_axis_if #(
  parameter int DATA_W  = 64,
  parameter bit KEEP_EN = 1,
  parameter int KEEP_W  = 8,
  parameter bit LAST_EN = 1,
  parameter bit ID_EN   = 0,
  parameter int ID_W    = 8,
  parameter bit DEST_EN = 0,
  parameter int DEST_W  = 8,
  parameter bit USER_EN = 0,
  parameter int USER_W  = 1
);
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [ID_W-1:0]   tid;
  logic [DEST_W-1:0] tdest;
  logic [USER_W-1:0] tuser;

  modport src (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
  modport snk (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/pkg_64b_skid.sv
// Two-entry skid buffer; in_ready comes straight from the occupancy register.
module pkg_64b_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [W-1:0] mem0, mem1;
  logic [1:0]   count;
  logic         pop, push_ok;

  assign in_ready  = ~count[1];
  assign out_valid = |count;
  assign out_data  = mem0;
  assign pop       = out_valid & out_ready;
  // a push into a full buffer is only legal alongside a pop
  assign push_ok   = push & (~count[1] | pop);

  always_ff @(posedge clk) begin
    if (rst) count <= 2'd0;
    else if (push_ok && !pop) count <= count + 2'd1;
    else if (!push_ok && pop) count <= count - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (pop) mem0 <= (count == 2'd2) ? mem1 : push_data;
    else if (push_ok && count == 2'd0) mem0 <= push_data;
    if (push_ok && (pop ? (count == 2'd2) : (count == 2'd1))) mem1 <= push_data;
  end
endmodule

// File: rtl/pkg_64b_split.sv
// Routes whole packets from one AXIS input to one of two outputs (or drops
// them), deciding on the first beat's tdest and holding until tlast.
module pkg_64b_split
  import pkg_64b_split_pkg::*;
#(
  parameter bit DROP_EN = 1,
  parameter int CNT_W   = 32,
  parameter int DEST_P1 = 0,
  parameter int DEST_P2 = 1
) (
  input  logic             clk,
  input  logic             rst,
  taxi_axis_if.snk         s_axis,
  taxi_axis_if.src         m_axis1,
  taxi_axis_if.src         m_axis2,
  output logic [CNT_W-1:0] pkt_cnt1,
  output logic [CNT_W-1:0] pkt_cnt2,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             busy
);
  localparam int ID_W   = s_axis.ID_W;
  localparam int DEST_W = s_axis.DEST_W;
  localparam int USER_W = s_axis.USER_W;
  localparam int PW     = BUS_W + KEEP_W + 1 + ID_W + DEST_W + USER_W;

  if (s_axis.DATA_W != BUS_W || m_axis1.DATA_W != BUS_W || m_axis2.DATA_W != BUS_W ||
      s_axis.KEEP_W != KEEP_W || m_axis1.KEEP_W != KEEP_W || m_axis2.KEEP_W != KEEP_W ||
      m_axis1.ID_W != ID_W || m_axis2.ID_W != ID_W || m_axis1.DEST_W != DEST_W ||
      m_axis2.DEST_W != DEST_W || m_axis1.USER_W != USER_W || m_axis2.USER_W != USER_W)
  begin : g_param_chk
    $fatal(1, "pkg_64b_split: interface parameter mismatch");
  end

  logic [KEEP_W-1:0] keep;
  logic              last;
  logic [ID_W-1:0]   id;
  logic [DEST_W-1:0] dest;
  logic [USER_W-1:0] user;
  logic [PW-1:0]     in_pay, out_pay1, out_pay2;

  assign keep   = s_axis.KEEP_EN ? s_axis.tkeep : '1;
  assign last   = s_axis.LAST_EN ? s_axis.tlast : 1'b1;
  assign id     = s_axis.ID_EN   ? s_axis.tid   : '0;
  assign dest   = s_axis.DEST_EN ? s_axis.tdest : '0;
  assign user   = s_axis.USER_EN ? s_axis.tuser : '0;
  assign in_pay = {s_axis.tdata, keep, last, id, dest, user};

  route_t state, state_nx, dec, cur;
  logic   ready, hs, nf1, nf2, push1, push2;

  always_comb begin
    if (dest == DEST_W'(DEST_P1))      dec = ST_P1;
    else if (dest == DEST_W'(DEST_P2)) dec = ST_P2;
    else                               dec = DROP_EN ? ST_DROP : ST_P1;
  end

  // IDLE waits for room in both buffers so the route decided this cycle can't overflow
  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    cur      = (state == ST_IDLE) ? dec : state;
    unique case (state)
      ST_IDLE: ready = nf1 & nf2;
      ST_P1:   ready = nf1;
      ST_P2:   ready = nf2;
      default: ready = 1'b1;
    endcase
    ready = ready & ~rst;
    if (s_axis.tvalid && ready) state_nx = last ? ST_IDLE : cur;
  end

  assign s_axis.tready = ready;
  assign hs    = s_axis.tvalid & ready;
  assign push1 = hs & (cur == ST_P1);
  assign push2 = hs & (cur == ST_P2);
  assign busy  = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      pkt_cnt1 <= '0;
      pkt_cnt2 <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_nx;
      if (hs && last) begin
        unique case (cur)
          ST_P1:   pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
          ST_P2:   pkt_cnt2 <= pkt_cnt2 + CNT_W'(1);
          ST_DROP: drop_cnt <= drop_cnt + CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

  pkg_64b_skid #(.W(PW)) u_skid1 (
    .clk(clk), .rst(rst), .push(push1), .push_data(in_pay), .in_ready(nf1),
    .out_valid(m_axis1.tvalid), .out_ready(m_axis1.tready), .out_data(out_pay1)
  );

  pkg_64b_skid #(.W(PW)) u_skid2 (
    .clk(clk), .rst(rst), .push(push2), .push_data(in_pay), .in_ready(nf2),
    .out_valid(m_axis2.tvalid), .out_ready(m_axis2.tready), .out_data(out_pay2)
  );

  assign {m_axis1.tdata, m_axis1.tkeep, m_axis1.tlast, m_axis1.tid, m_axis1.tdest, m_axis1.tuser} = out_pay1;
  assign {m_axis2.tdata, m_axis2.tkeep, m_axis2.tlast, m_axis2.tid, m_axis2.tdest, m_axis2.tuser} = out_pay2;
endmodule

// File: tb/tb_pkg_64b_split.sv
// Bench for pkg_64b_split: packet-level model with per-port expected queues.
module tb_pkg_64b_split;
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [3:0]  id;
    logic [7:0]  dest;
    logic [1:0]  user;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  taxi_axis_if #(.DATA_W(64), .KEEP_W(8), .ID_EN(1), .ID_W(4), .DEST_EN(1), .DEST_W(8),
                 .USER_EN(1), .USER_W(2)) s (), m1 (), m2 (), sb (), m1b (), m2b ();

  logic [31:0] pc1, pc2, dc, pc1b, pc2b, dcb;
  logic        busy, busyb;

  pkg_64b_split #(.DROP_EN(1)) dut (
    .clk(clk), .rst(rst), .s_axis(s), .m_axis1(m1), .m_axis2(m2),
    .pkt_cnt1(pc1), .pkt_cnt2(pc2), .drop_cnt(dc), .busy(busy)
  );

  pkg_64b_split #(.DROP_EN(0)) dut_nodrop (
    .clk(clk), .rst(rst), .s_axis(sb), .m_axis1(m1b), .m_axis2(m2b),
    .pkt_cnt1(pc1b), .pkt_cnt2(pc2b), .drop_cnt(dcb), .busy(busyb)
  );

  int checks = 0, errors = 0, cyc = 0, in_hs = 0, waits = 0;
  int mode1 = 0, mode2 = 0;  // sink ready: 0 always, 1 random, 2 stalled
  int n1 = 0, n2 = 0, nd = 0;
  beat_t exp1[$], exp2[$], obs1[$], obs2[$], obs1b[$], obs2b[$];
  int    exp_cyc1[$], exp_cyc2[$], obs_cyc1[$], obs_cyc2[$];

  function automatic logic rdy(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ($urandom_range(0, 3) != 0);
    return 1'b0;
  endfunction

  // Packet-level routing rule of the DROP_EN=1 instance: 0 means dropped
  function automatic int port_of(input int dest);
    if (dest == 0) return 1;
    if (dest == 1) return 2;
    return 0;
  endfunction

  initial begin
    m1.tready = 1'b1; m2.tready = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      m1.tready = rdy(mode1);
      m2.tready = rdy(mode2);
    end
  end

  always @(negedge clk) begin
    if (m1.tvalid && m1.tready) begin
      obs1.push_back({m1.tdata, m1.tkeep, m1.tlast, m1.tid, m1.tdest, m1.tuser});
      obs_cyc1.push_back(cyc);
    end
    if (m2.tvalid && m2.tready) begin
      obs2.push_back({m2.tdata, m2.tkeep, m2.tlast, m2.tid, m2.tdest, m2.tuser});
      obs_cyc2.push_back(cyc);
    end
    if (m1b.tvalid && m1b.tready) obs1b.push_back({m1b.tdata, m1b.tkeep, m1b.tlast, m1b.tid, m1b.tdest, m1b.tuser});
    if (m2b.tvalid && m2b.tready) obs2b.push_back({m2b.tdata, m2b.tkeep, m2b.tlast, m2b.tid, m2b.tdest, m2b.tuser});
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic clear_q();
    exp1.delete(); exp2.delete(); obs1.delete(); obs2.delete();
    exp_cyc1.delete(); exp_cyc2.delete(); obs_cyc1.delete(); obs_cyc2.delete();
    obs1b.delete(); obs2b.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send_beat(input beat_t b, output int hcyc);
    int w;
    w = 0;
    {s.tdata, s.tkeep, s.tlast, s.tid, s.tdest, s.tuser} = b;
    s.tvalid = 1'b1;
    @(negedge clk);
    while (s.tready !== 1'b1 && w < 500) begin w++; @(negedge clk); end
    waits += w;
    if (w >= 500) begin
      checks++; errors++;
      $display("FAIL send_timeout: tready low for %0d cycles, want handshake", w);
      hcyc = -1;
    end else begin
      hcyc = cyc;
      in_hs++;
    end
    @(posedge clk); #1;
    s.tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int dest, input int len, input int base, input logic [7:0] last_keep);
    beat_t b;
    int hc, p;
    p = port_of(dest);
    for (int i = 0; i < len; i++) begin
      b.data = (base >= 0) ? 64'(base + i) : {$urandom, $urandom};
      b.keep = (i == len - 1) ? last_keep : 8'hFF;
      b.last = (i == len - 1);
      b.id   = 4'($urandom);
      b.dest = 8'(dest);
      b.user = 2'($urandom);
      send_beat(b, hc);
      if (p == 1) begin exp1.push_back(b); exp_cyc1.push_back(hc); end
      else if (p == 2) begin exp2.push_back(b); exp_cyc2.push_back(hc); end
    end
    if (p == 1) n1++; else if (p == 2) n2++; else nd++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((obs1.size() < exp1.size() || obs2.size() < exp2.size()) && n < budget) begin
      @(posedge clk); n++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s.tvalid = 1'b0; sb.tvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (s.tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b want 0", s.tready); end
    checks++; if (m1.tvalid !== 1'b0 || m2.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b%b want 00", m1.tvalid, m2.tvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (pc1 !== 0 || pc2 !== 0 || dc !== 0) begin errors++; $display("FAIL rst_cnt: got %0d/%0d/%0d want 0/0/0", pc1, pc2, dc); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (s.tready !== 1'b1) begin errors++; $display("FAIL idle_tready: got %b want 1", s.tready); end
    @(posedge clk); #1;
  endtask

  task automatic test_three_packets();
    clear_q(); waits = 0;
    send_pkt(0, 4, 1, 8'hFF);
    send_pkt(1, 4, 5, 8'hFF);
    send_pkt(0, 4, 9, 8'hFF);
    drain(200);
    checks++; if (obs1.size() != 8 || obs2.size() != 4) begin errors++; $display("FAIL three_sizes: got %0d/%0d want 8/4", obs1.size(), obs2.size()); end
    for (int i = 0; i < exp1.size() && i < obs1.size(); i++) begin
      checks++; if (obs1[i] !== exp1[i]) begin errors++; $display("FAIL three_p1_beat%0d: got %h want %h", i, obs1[i], exp1[i]); end
      checks++; if (obs_cyc1[i] != exp_cyc1[i] + 1) begin errors++; $display("FAIL three_p1_lat%0d: got cycle %0d want %0d", i, obs_cyc1[i], exp_cyc1[i] + 1); end
    end
    for (int i = 0; i < exp2.size() && i < obs2.size(); i++) begin
      checks++; if (obs2[i] !== exp2[i]) begin errors++; $display("FAIL three_p2_beat%0d: got %h want %h", i, obs2[i], exp2[i]); end
      checks++; if (obs_cyc2[i] != exp_cyc2[i] + 1) begin errors++; $display("FAIL three_p2_lat%0d: got cycle %0d want %0d", i, obs_cyc2[i], exp_cyc2[i] + 1); end
    end
    checks++; if (waits != 0) begin errors++; $display("FAIL three_bubbles: got %0d stall cycles want 0", waits); end
    checks++; if (pc1 !== 2 || pc2 !== 1) begin errors++; $display("FAIL three_cnt: got %0d/%0d want 2/1", pc1, pc2); end
  endtask

  task automatic test_single_beat();
    logic [31:0] c1, c2;
    clear_q(); waits = 0;
    c1 = pc1; c2 = pc2;
    for (int i = 0; i < 10; i++) begin
      send_pkt(i % 2, 1, 100 + i, 8'h3C);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy%0d: got %b want 0", i, busy); end
    end
    drain(200);
    checks++; if (obs1.size() != 5 || obs2.size() != 5) begin errors++; $display("FAIL single_sizes: got %0d/%0d want 5/5", obs1.size(), obs2.size()); end
    for (int i = 0; i < exp1.size() && i < obs1.size(); i++) begin
      checks++; if (obs1[i] !== exp1[i]) begin errors++; $display("FAIL single_p1_beat%0d: got %h want %h", i, obs1[i], exp1[i]); end
    end
    for (int i = 0; i < exp2.size() && i < obs2.size(); i++) begin
      checks++; if (obs2[i] !== exp2[i]) begin errors++; $display("FAIL single_p2_beat%0d: got %h want %h", i, obs2[i], exp2[i]); end
    end
    checks++; if (pc1 - c1 !== 5 || pc2 - c2 !== 5) begin errors++; $display("FAIL single_cnt: got +%0d/+%0d want +5/+5", pc1 - c1, pc2 - c2); end
    checks++; if (waits != 0) begin errors++; $display("FAIL single_tput: got %0d stall cycles want 0", waits); end
  endtask

  task automatic test_drop();
    logic [31:0] d0, b0;
    beat_t b, sent[$];
    clear_q(); waits = 0;
    d0 = dc; b0 = pc1b;
    send_pkt(5, 3, 200, 8'h07);
    drain(20);
    checks++; if (obs1.size() != 0 || obs2.size() != 0) begin errors++; $display("FAIL drop_out: got %0d/%0d beats want 0/0", obs1.size(), obs2.size()); end
    checks++; if (dc - d0 !== 1) begin errors++; $display("FAIL drop_cnt: got +%0d want +1", dc - d0); end
    checks++; if (waits != 0) begin errors++; $display("FAIL drop_tready: got %0d stall cycles want 0", waits); end
    m1b.tready = 1'b1; m2b.tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b = {64'(300 + i), (i == 2) ? 8'h07 : 8'hFF, (i == 2), 4'($urandom), 8'd5, 2'($urandom)};
      sent.push_back(b);
      {sb.tdata, sb.tkeep, sb.tlast, sb.tid, sb.tdest, sb.tuser} = b;
      sb.tvalid = 1'b1;
      @(negedge clk);
      checks++; if (sb.tready !== 1'b1) begin errors++; $display("FAIL nodrop_tready%0d: got %b want 1", i, sb.tready); end
      @(posedge clk); #1;
    end
    sb.tvalid = 1'b0;
    repeat (4) @(posedge clk); #1;
    checks++; if (obs1b.size() != 3 || obs2b.size() != 0) begin errors++; $display("FAIL nodrop_sizes: got %0d/%0d want 3/0", obs1b.size(), obs2b.size()); end
    for (int i = 0; i < 3 && i < obs1b.size(); i++) begin
      checks++; if (obs1b[i] !== sent[i]) begin errors++; $display("FAIL nodrop_beat%0d: got %h want %h", i, obs1b[i], sent[i]); end
    end
    checks++; if (pc1b - b0 !== 1) begin errors++; $display("FAIL nodrop_cnt: got +%0d want +1", pc1b - b0); end
  endtask

  task automatic test_backpressure();
    int h0;
    clear_q();
    mode2 = 2;
    @(posedge clk); #1;
    h0 = in_hs;
    fork
      begin
        send_pkt(0, 4, 400, 8'hFF);
        send_pkt(1, 6, 500, 8'h0F);
      end
      begin
        repeat (20) @(negedge clk);
        checks++; if (in_hs - h0 - 4 > 2) begin errors++; $display("FAIL bp_accepted: got %0d beats while stalled want <=2", in_hs - h0 - 4); end
        checks++; if (s.tready !== 1'b0) begin errors++; $display("FAIL bp_tready: got %b want 0", s.tready); end
        checks++; if (obs2.size() != 0) begin errors++; $display("FAIL bp_leak: got %0d beats on stalled port want 0", obs2.size()); end
        @(posedge clk); #1;
        mode2 = 0;
      end
    join
    drain(200);
    checks++; if (obs1.size() != 4 || obs2.size() != 6) begin errors++; $display("FAIL bp_sizes: got %0d/%0d want 4/6", obs1.size(), obs2.size()); end
    for (int i = 0; i < exp1.size() && i < obs1.size(); i++) begin
      checks++; if (obs1[i] !== exp1[i] || obs_cyc1[i] != exp_cyc1[i] + 1) begin
        errors++; $display("FAIL bp_p1_beat%0d: got %h@%0d want %h@%0d", i, obs1[i], obs_cyc1[i], exp1[i], exp_cyc1[i] + 1);
      end
    end
    for (int i = 0; i < exp2.size() && i < obs2.size(); i++) begin
      checks++; if (obs2[i] !== exp2[i]) begin errors++; $display("FAIL bp_p2_beat%0d: got %h want %h", i, obs2[i], exp2[i]); end
    end
    if (obs2.size() == 6) begin
      checks++; if (obs2[5].keep !== 8'h0F || obs2[5].last !== 1'b1) begin errors++; $display("FAIL bp_last_keep: got %h/%b want 0f/1", obs2[5].keep, obs2[5].last); end
    end
  endtask

  task automatic test_random();
    logic [31:0] c1, c2, cd;
    clear_q();
    n1 = 0; n2 = 0; nd = 0;
    c1 = pc1; c2 = pc2; cd = dc;
    mode1 = 1; mode2 = 1;
    for (int p = 0; p < 1000; p++)
      send_pkt($urandom_range(0, 2), $urandom_range(1, 16), -1, 8'($urandom_range(1, 255)));
    drain(2000);
    mode1 = 0; mode2 = 0;
    checks++; if (obs1.size() != exp1.size()) begin errors++; $display("FAIL rand_p1_size: got %0d want %0d", obs1.size(), exp1.size()); end
    checks++; if (obs2.size() != exp2.size()) begin errors++; $display("FAIL rand_p2_size: got %0d want %0d", obs2.size(), exp2.size()); end
    for (int i = 0; i < exp1.size() && i < obs1.size(); i++) begin
      checks++; if (obs1[i] !== exp1[i]) begin errors++; $display("FAIL rand_p1_beat%0d: got %h want %h", i, obs1[i], exp1[i]); end
    end
    for (int i = 0; i < exp2.size() && i < obs2.size(); i++) begin
      checks++; if (obs2[i] !== exp2[i]) begin errors++; $display("FAIL rand_p2_beat%0d: got %h want %h", i, obs2[i], exp2[i]); end
    end
    checks++; if (pc1 - c1 !== n1) begin errors++; $display("FAIL rand_cnt1: got +%0d want +%0d", pc1 - c1, n1); end
    checks++; if (pc2 - c2 !== n2) begin errors++; $display("FAIL rand_cnt2: got +%0d want +%0d", pc2 - c2, n2); end
    checks++; if (dc - cd !== nd) begin errors++; $display("FAIL rand_drop: got +%0d want +%0d", dc - cd, nd); end
  endtask

  task automatic test_reset_mid();
    beat_t b;
    int hc;
    clear_q();
    for (int i = 0; i < 2; i++) begin
      b = {64'(600 + i), 8'hFF, 1'b0, 4'd1, 8'd0, 2'd0};
      send_beat(b, hc);
    end
    {s.tdata, s.tkeep, s.tlast, s.tid, s.tdest, s.tuser} = {64'd602, 8'hFF, 1'b0, 4'd1, 8'd0, 2'd0};
    s.tvalid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    s.tvalid = 1'b0;
    @(negedge clk);
    checks++; if (m1.tvalid !== 1'b0 || m2.tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid: got %b%b want 00", m1.tvalid, m2.tvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (pc1 !== 0 || pc2 !== 0 || dc !== 0) begin errors++; $display("FAIL rstmid_cnt: got %0d/%0d/%0d want 0/0/0", pc1, pc2, dc); end
    @(posedge clk); #1;
    clear_q();
    send_pkt(1, 3, 700, 8'h01);
    drain(100);
    checks++; if (obs1.size() != 0 || obs2.size() != 3) begin errors++; $display("FAIL rstmid_sizes: got %0d/%0d want 0/3", obs1.size(), obs2.size()); end
    for (int i = 0; i < exp2.size() && i < obs2.size(); i++) begin
      checks++; if (obs2[i] !== exp2[i]) begin errors++; $display("FAIL rstmid_beat%0d: got %h want %h", i, obs2[i], exp2[i]); end
    end
    checks++; if (pc2 !== 1 || pc1 !== 0) begin errors++; $display("FAIL rstmid_after_cnt: got %0d/%0d want 0/1", pc1, pc2); end
  endtask

  initial begin
    s.tvalid = 1'b0; s.tdata = '0; s.tkeep = '0; s.tlast = 1'b0; s.tid = '0; s.tdest = '0; s.tuser = '0;
    sb.tvalid = 1'b0; sb.tdata = '0; sb.tkeep = '0; sb.tlast = 1'b0; sb.tid = '0; sb.tdest = '0; sb.tuser = '0;
    m1b.tready = 1'b1; m2b.tready = 1'b1;
    test_reset();
    test_three_packets();
    test_single_beat();
    test_drop();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
